// File: rtl/mont_final_sub.sv
// mont_final_sub: digit-serial conditional subtract, R = (S >= M) ? S - M : S, one W-bit digit per cycle
module mont_final_sub #(
  parameter int K = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [K:0]   S,
  input  logic [K-1:0] M,
  output logic         busy,
  output logic         done,
  output logic [K-1:0] R,
  output logic         sub_taken
);
  localparam int ND = (K + W - 1) / W;
  localparam int PW = ND * W;
  localparam int LW = K - (ND - 1) * W;
  localparam int CW = ND > 1 ? $clog2(ND) : 1;
  typedef enum logic [1:0] {IDLE, SUB, SEL} state_t;
  state_t         state_q;
  logic [PW-1:0]  s_q, m_q;
  logic           top_q, borrow_q;
  logic [CW-1:0]  cnt_q;
  logic [K-1:0]   diff_q, diff_d;
  logic [W:0]     sub_d;
  logic           last_d, sub_taken_d;
  // one digit of S - M - borrow; the last digit only contributes its LW valid bits to the difference
  always_comb begin
    sub_d = {1'b0, s_q[W-1:0]} - {1'b0, m_q[W-1:0]} - {{W{1'b0}}, borrow_q};
    last_d = cnt_q == CW'(ND - 1);
    diff_d = last_d ? {sub_d[LW-1:0], diff_q[K-1:LW]} : {sub_d[W-1:0], diff_q[K-1:W]};
    sub_taken_d = top_q | ~borrow_q;
  end
  // sequencer: load on start, subtract a digit per SUB cycle, select and publish in SEL
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      s_q <= '0;
      m_q <= '0;
      top_q <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q <= '0;
      diff_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      R <= '0;
      sub_taken <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          s_q <= PW'(S[K-1:0]);
          m_q <= PW'(M);
          top_q <= S[K];
          borrow_q <= 1'b0;
          cnt_q <= '0;
          busy <= 1'b1;
          state_q <= SUB;
        end
        SUB: begin
          s_q <= {s_q[W-1:0], s_q[PW-1:W]};
          m_q <= {{W{1'b0}}, m_q[PW-1:W]};
          diff_q <= diff_d;
          borrow_q <= sub_d[W];
          cnt_q <= cnt_q + 1'b1;
          state_q <= last_d ? SEL : SUB;
        end
        SEL: begin
          R <= sub_taken_d ? diff_q : s_q[K-1:0];
          sub_taken <= sub_taken_d;
          done <= 1'b1;
          busy <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mont_final_sub.sv
// tb_mont_final_sub: random and directed checks of K=32 and K=30 instances against an arithmetic model
module tb_mont_final_sub;
  localparam int ND = 4;
  logic        clk, rst, start;
  logic [32:0] s32;
  logic [31:0] m32, r32;
  logic [30:0] s30;
  logic [29:0] m30, r30;
  logic        busy32, done32, sub32, busy30, done30, sub30;
  int          n_cmp = 0, n_bad = 0;
  bit          chk_en = 0;
  mont_final_sub #(.K(32), .W(8)) u32 (.clk(clk), .rst(rst), .start(start), .S(s32), .M(m32),
    .busy(busy32), .done(done32), .R(r32), .sub_taken(sub32));
  mont_final_sub #(.K(30), .W(8)) u30 (.clk(clk), .rst(rst), .start(start), .S(s30), .M(m30),
    .busy(busy30), .done(done30), .R(r30), .sub_taken(sub30));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // behavioural model: an accepted job yields its reduced value ND+1 edges later
  logic [63:0] pr[2], mr[2], sv, mv;
  logic        ps[2], ms[2];
  bit          mbusy = 0, mdone = 0;
  int          mcnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      mcnt = 0; mbusy = 0; mdone = 0;
      for (int i = 0; i < 2; i++) begin mr[i] = 0; ms[i] = 0; end
    end else begin
      mdone = 0;
      if (mcnt == 0) begin
        if (start) begin
          for (int i = 0; i < 2; i++) begin
            sv = i ? 64'(s30) : 64'(s32);
            mv = i ? 64'(m30) : 64'(m32);
            ps[i] = sv >= mv;
            pr[i] = (ps[i] ? sv - mv : sv) & (i ? 64'h3FFF_FFFF : 64'hFFFF_FFFF);
          end
          mcnt = ND + 1;
          mbusy = 1;
        end
      end else begin
        mcnt--;
        if (mcnt == 0) begin
          mdone = 1; mbusy = 0;
          for (int i = 0; i < 2; i++) begin mr[i] = pr[i]; ms[i] = ps[i]; end
        end
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("busy32", 64'(busy32), 64'(mbusy));
    chk("done32", 64'(done32), 64'(mdone));
    chk("r32", 64'(r32), mr[0]);
    chk("sub32", 64'(sub32), 64'(ms[0]));
    chk("busy30", 64'(busy30), 64'(mbusy));
    chk("done30", 64'(done30), 64'(mdone));
    chk("r30", 64'(r30), mr[1]);
    chk("sub30", 64'(sub30), 64'(ms[1]));
  end
  task automatic rnd();
    logic [63:0] m, t;
    m = 64'($urandom_range(32'hFFFF_FFFF, 1));
    t = {$urandom, $urandom};
    m32 = m[31:0];
    s32 = 33'(t % (2 * m));
    m = 64'($urandom_range(32'h3FFF_FFFF, 1));
    t = {$urandom, $urandom};
    m30 = m[29:0];
    s30 = 31'(t % (2 * m));
  endtask
  task automatic run(input logic [32:0] a_s, input logic [31:0] a_m, input logic [30:0] b_s,
                     input logic [29:0] b_m, input logic [31:0] er0, input bit es0,
                     input logic [29:0] er1, input bit es1);
    int n;
    @(posedge clk); #2;
    s32 = a_s; m32 = a_m; s30 = b_s; m30 = b_m; start = 1;
    n = 0;
    do begin
      @(posedge clk); #1;
      start = 0;
      s32 = '1; m32 = '0; s30 = '1; m30 = '0;
      n++;
    end while (!done32 && n < 20);
    chk("latency", 64'(n - 1), 64'd5);
    chk("lit_r32", 64'(r32), 64'(er0));
    chk("lit_sub32", 64'(sub32), 64'(es0));
    chk("lit_r30", 64'(r30), 64'(er1));
    chk("lit_sub30", 64'(sub30), 64'(es1));
    chk("lit_busy_done", 64'(busy32), 64'd0);
  endtask
  initial begin
    int n;
    rst = 1; start = 0; s32 = 0; m32 = 0; s30 = 0; m30 = 0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #2;
    rst = 0;
    chk("rst_r32", 64'(r32), 64'd0);
    chk("rst_sub32", 64'(sub32), 64'd0);
    run(33'h0_0000_0005, 32'h0000_0007, 31'h3FFF_FFFF, 30'h2000_0001, 32'h5, 0, 30'h1FFF_FFFE, 1);
    run(33'h1_0000_0000, 32'hFFFF_FFF1, 31'h1000_0000, 30'h3000_0000, 32'hF, 1, 30'h1000_0000, 0);
    run(33'h0_8000_0001, 32'h8000_0001, 31'h5, 30'h7, 32'h0, 1, 30'h5, 0);
    run(33'h0_8000_0000, 32'h8000_0001, 31'h4000_0000, 30'h3FFF_FFF0, 32'h8000_0000, 0, 30'h10, 1);
    // start held high with fresh operands every cycle
    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #2;
      start = 1;
      rnd();
    end
    @(posedge clk); #2;
    start = 0;
    n = 0;
    while (mcnt != 0 && n < 20) begin @(posedge clk); #2; n++; end
    // abort at the second SUB edge
    @(posedge clk); #2;
    rnd(); start = 1;
    @(posedge clk); #2;
    start = 0;
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #2;
    rst = 0;
    chk("abort_r32", 64'(r32), 64'd0);
    chk("abort_busy30", 64'(busy30), 64'd0);
    n = 0;
    while (n < 8) begin @(posedge clk); #1; chk("abort_nodone", 64'(done32), 64'd0); n++; end
    run(33'h1_2345_6789, 32'hA000_0000, 31'h3000_0000, 30'h2000_0000, 32'h8345_6789, 1, 30'h1000_0000, 1);
    // random start pattern with random operands
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(3, 0) != 0);
      rnd();
    end
    @(posedge clk); #2;
    start = 0;
    n = 0;
    while (mcnt != 0 && n < 20) begin @(posedge clk); #2; n++; end
    chk("drain", 64'(mcnt), 64'd0);
    @(posedge clk); #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
